priority_irq_controller: RTL and testbench
==========================================

PRIORITY_IRQ_CONTROLLER -- requirements
Module: priority_irq_controller

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16, number of interrupt sources, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchronizer depth, legal range 2..3.
REQ-003 clk  input  1  single clock, same domain as the CPU bus (clk_2 at top level).
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 cs  input  1  register chip-select from address decode.
REQ-006 rwb  input  1  CPU read (1) / write (0).
REQ-007 addr  input  4  register offset.
REQ-008 i_data  input  8  CPU write data.
REQ-009 o_data  output  8  CPU read data.
REQ-010 irqb_in  input  NUM_IRQ  per-source interrupt request, active-low, asynchronous to clk.
REQ-011 irqb_master  output  1  combined interrupt to CPU, active-low, registered.

Function
REQ-012 Each irqb_in bit SHALL pass through SYNC_STAGES flops before any use.
REQ-013 Register map: 0x0 VECTOR (RO); 0x1 CMD (WO); 0x4-0x7 ENABLE bytes 0-3 (RW); 0x8-0xB MODE bytes 0-3 (RW, 1=falling-edge, 0=level); 0xC-0xF PENDING bytes 0-3 (read, write-1-to-clear); 0x2, 0x3 read 0x00, writes ignored.
REQ-014 Writes SHALL take effect at the posedge of clk where cs=1 and rwb=0; reads SHALL be combinational from cs, addr, and register state; o_data=0x00 when cs=0.
REQ-015 Bits at indices >= NUM_IRQ SHALL read 0 and ignore writes in every byte-wide register.
REQ-016 Edge-mode source: pending bit SHALL set on the clock after the synchronized input goes 1->0; pending bit SHALL hold until cleared by PENDING W1C or CMD.
REQ-017 Level-mode source: pending bit SHALL equal the registered synchronized input inverted; W1C and CMD SHALL have no effect on it.
REQ-018 Simultaneous edge set and clear on the same bit in the same cycle: set SHALL win.
REQ-019 CMD write: i_data[7]=1 SHALL clear all edge-mode pending bits; otherwise it SHALL clear the pending bit at index i_data[4:0], ignored if the index is >= NUM_IRQ.
REQ-020 active = pending & enable; irqb_master SHALL be registered as ~|active, giving a latency of one clock after active changes.
REQ-021 Latency budget: irqb_in falling sampled at edge k SHALL produce irqb_master=0 after edge k+SYNC_STAGES+2 with enable already set.
REQ-022 VECTOR read: {valid_n, 2'b00, idx[4:0]}; idx SHALL be the lowest-numbered active bit (index 0 = highest priority); valid_n=1 and idx=0 when no bit is active.
REQ-023 A VECTOR read SHALL have no side effects (no auto-acknowledge).
REQ-024 Changing MODE on a source SHALL clear that source's pending bit in the same write cycle.
REQ-025 Clearing an ENABLE bit SHALL NOT clear pending; re-enabling SHALL re-assert irqb_master per REQ-020.

Reset
REQ-026 On reset_n=0 the following SHALL be held asynchronously: ENABLE=0, MODE=0, PENDING=0, synchronizer flops=1, edge-history flops=1, irqb_master=1.
REQ-027 Deasserting reset_n mid-activity SHALL NOT produce spurious edge pending, because history flops reset to the inactive level.

Structure
REQ-028 Shared package irq_pkg SHALL hold: register offset constants, MAX_IRQ=32, and a vector-register bitfield typedef.
REQ-029 Sub-module irq_prio_enc SHALL implement a parametrised lowest-index-first priority encoder (inputs: NUM_IRQ-bit vector; outputs: valid, 5-bit idx).
REQ-030 Registers beyond NUM_IRQ SHALL be eliminated by constant parameters, with no logic added for unused bits.

Verification
REQ-031 NUM_IRQ=16: reset, write ENABLE0=0x01, MODE0=0x01, pulse irqb_in[0] low 1 clk -> irqb_master=0 at edge k+4; VECTOR=0x00; CMD write 0x00 -> irqb_master=1 one clock later.
REQ-032 Level mode on source 9, ENABLE1=0x02: hold irqb_in[9] low -> VECTOR=0x09; write 0x02 to PENDING1 -> remains pending; release input -> VECTOR=0x80, irqb_master=1.
REQ-033 Edge sources 3 and 12 both pending and enabled -> VECTOR=0x03; CMD 0x03 -> VECTOR=0x0C; CMD 0x80 -> VECTOR=0x80.
REQ-034 Edge on source 5 in the same cycle as a W1C of PENDING0 bit 5 -> pending bit 5 remains 1.
REQ-035 NUM_IRQ=4: write 0xFF to ENABLE0 and ENABLE1 -> read back 0x0F and 0x00; CMD 0x07 -> no state change.
REQ-036 Assert reset_n=0 while source 2 is pending and irqb_in[2]=0, then release -> PENDING=0, irqb_master=1, and no new edge pending until irqb_in[2] goes high then low.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the priority interrupt controller: register offsets,
// source-count ceiling and the VECTOR register layout.
package irq_pkg;

    localparam int MAX_IRQ = 32;
    localparam int IDX_W   = 5;

    localparam logic [3:0] ADDR_VECTOR  = 4'h0;
    localparam logic [3:0] ADDR_CMD     = 4'h1;
    localparam logic [3:0] ADDR_ENABLE  = 4'h4;
    localparam logic [3:0] ADDR_MODE    = 4'h8;
    localparam logic [3:0] ADDR_PENDING = 4'hC;

    typedef struct packed {
        logic             valid_n;
        logic [1:0]       rsvd;
        logic [IDX_W-1:0] idx;
    } irq_vec_t;

endpackage

// File: rtl/priority_irq_controller_if.sv
// CPU register bus seen by the interrupt controller.
interface priority_irq_controller_if;

    logic       cs;
    logic       rwb;
    logic [3:0] addr;
    logic [7:0] i_data;
    logic [7:0] o_data;

    modport master (output cs, rwb, addr, i_data, input o_data);
    modport slave  (input cs, rwb, addr, i_data, output o_data);

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; idx is 0 when nothing is requested.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 16
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Walk downward so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/priority_irq_controller.sv
// Priority interrupt controller: synchronised active-low sources, per-source
// edge/level mode, enable mask, W1C pending and a registered combined irqb.
module priority_irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    priority_irq_controller_if.slave   bus,
    input  logic [NUM_IRQ-1:0]         irqb_in,
    output logic                       irqb_master
);

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] hist_q, prev_q;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] clr, fall, active;
    logic               irqb_q, irqb_d;
    logic               wr, wr_en, wr_mode, wr_pend, wr_cmd;
    logic               enc_valid;
    logic [IDX_W-1:0]   enc_idx;
    irq_vec_t           vec;
    logic [MAX_IRQ-1:0] en_x, mode_x, pend_x;
    logic [7:0]         rdata;

    assign wr      = bus.cs & ~bus.rwb;
    assign wr_en   = wr && (bus.addr[3:2] == ADDR_ENABLE[3:2]);
    assign wr_mode = wr && (bus.addr[3:2] == ADDR_MODE[3:2]);
    assign wr_pend = wr && (bus.addr[3:2] == ADDR_PENDING[3:2]);
    assign wr_cmd  = wr && (bus.addr == ADDR_CMD);

    // hist_q is the registered synchronised input; prev_q is one cycle older.
    assign fall   = prev_q & ~hist_q;
    assign active = pend_q & enable_q;
    assign irqb_d = ~|active;

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        clr      = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.addr[1:0] == 2'(i / 8)) begin
                if (wr_en)   enable_d[i] = bus.i_data[i % 8];
                if (wr_mode) mode_d[i]   = bus.i_data[i % 8];
                if (wr_pend) clr[i]      = bus.i_data[i % 8];
            end
            if (wr_cmd && (bus.i_data[7] || (bus.i_data[4:0] == 5'(i)))) clr[i] = 1'b1;
            // A mode change discards whatever the old mode had latched.
            if (mode_d[i] != mode_q[i])
                pend_d[i] = 1'b0;
            else if (mode_q[i])
                pend_d[i] = fall[i] | (pend_q[i] & ~clr[i]);
            else
                pend_d[i] = ~hist_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '1;
            hist_q   <= '1;
            prev_q   <= '1;
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            irqb_q   <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], irqb_in};
            hist_q   <= sync_q[SYNC_STAGES-1];
            prev_q   <= hist_q;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            irqb_q   <= irqb_d;
        end
    end

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
        .req_i   (active),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    assign vec    = '{valid_n: ~enc_valid, rsvd: 2'b00, idx: enc_idx};
    assign en_x   = MAX_IRQ'(enable_q);
    assign mode_x = MAX_IRQ'(mode_q);
    assign pend_x = MAX_IRQ'(pend_q);

    always_comb begin
        rdata = 8'h00;
        if (bus.cs) begin
            case (bus.addr[3:2])
                2'b00:   if (bus.addr == ADDR_VECTOR) rdata = vec;
                2'b01:   rdata = en_x[{bus.addr[1:0], 3'b000} +: 8];
                2'b10:   rdata = mode_x[{bus.addr[1:0], 3'b000} +: 8];
                default: rdata = pend_x[{bus.addr[1:0], 3'b000} +: 8];
            endcase
        end
    end

    assign bus.o_data  = rdata;
    assign irqb_master = irqb_q;

endmodule

// File: tb/tb_priority_irq_controller.sv
// Scoreboard bench: reads push expected data/irqb, a negedge monitor compares.
module tb_priority_irq_controller;
    import irq_pkg::*;

    localparam int N  = 16;
    localparam int S  = 2;
    localparam int N4 = 4;
    localparam logic [31:0] NMASK = 32'h0000_FFFF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  irqb = '1;
    logic [N4-1:0] irqb4 = '1;
    logic          irqb_master, irqb_master4;

    priority_irq_controller_if bus ();
    priority_irq_controller_if bus4 ();

    priority_irq_controller #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .irqb_in(irqb), .irqb_master(irqb_master));
    priority_irq_controller #(.NUM_IRQ(N4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(bus4), .irqb_in(irqb4), .irqb_master(irqb_master4));

    always #5 clk = ~clk;

    typedef struct {logic [7:0] d; logic ib; logic [3:0] a;} exp_t;
    exp_t sbq[$];
    exp_t sbq4[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model: register state plus a delay line of sampled inputs.
    logic [31:0] m_en, m_mode, m_pend;
    logic        m_irqb;
    logic [31:0] m_hist [0:7];

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_pend = 0; m_irqb = 1'b1;
        for (int j = 0; j < 8; j++) m_hist[j] = '1;
    endtask

    task automatic model_step();
        logic [31:0] bm, fd, clr, nmode, fall, lvl;
        m_irqb = ((m_pend & m_en) == 0);
        for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = {16'hFFFF, irqb};
        bm    = 32'hFF << (8 * bus.addr[1:0]);
        fd    = 32'(bus.i_data) << (8 * bus.addr[1:0]);
        clr   = 0;
        nmode = m_mode;
        if (bus.cs && !bus.rwb) begin
            if (bus.addr[3:2] == 2'd1) m_en = ((m_en & ~bm) | fd) & NMASK;
            if (bus.addr[3:2] == 2'd2) nmode = ((m_mode & ~bm) | fd) & NMASK;
            if (bus.addr[3:2] == 2'd3) clr = fd;
            if (bus.addr == 4'h1) clr = bus.i_data[7] ? 32'hFFFF_FFFF : (32'd1 << bus.i_data[4:0]);
        end
        // Falling edge as seen at the synchroniser output, one register later.
        fall   = m_hist[S+2] & ~m_hist[S+1];
        lvl    = ~m_hist[S+1];
        m_pend = ((m_mode & (fall | (m_pend & ~clr))) | (~m_mode & lvl))
                 & ~(nmode ^ m_mode) & NMASK;
        m_mode = nmode;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    function automatic logic [7:0] m_read(input logic [3:0] a);
        logic [31:0] act;
        act = m_pend & m_en;
        case (a[3:2])
            2'd0: begin
                if (a != 4'h0) return 8'h00;
                for (int i = 0; i < 32; i++) if (act[i]) return 8'(i);
                return 8'h80;
            end
            2'd1:    return m_en[8*a[1:0] +: 8];
            2'd2:    return m_mode[8*a[1:0] +: 8];
            default: return m_pend[8*a[1:0] +: 8];
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.cs = 0; bus.rwb = 1; bus4.cs = 0; bus4.rwb = 1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.cs = 1; bus.rwb = 0; bus.addr = a; bus.i_data = d;
        bus4.cs = 0; bus4.rwb = 1;
    endtask

    task automatic rd(input logic [3:0] a, input bit use_m, input logic [7:0] d, input logic ib);
        exp_t e;
        @(posedge clk); #1;
        bus.cs = 1; bus.rwb = 1; bus.addr = a; bus.i_data = 8'h00;
        bus4.cs = 0; bus4.rwb = 1;
        e.a = a;
        e.d = use_m ? m_read(a) : d;
        e.ib = use_m ? m_irqb : ib;
        sbq.push_back(e);
    endtask

    task automatic wr4(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus4.cs = 1; bus4.rwb = 0; bus4.addr = a; bus4.i_data = d;
        bus.cs = 0; bus.rwb = 1;
    endtask

    task automatic rd4(input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        @(posedge clk); #1;
        bus4.cs = 1; bus4.rwb = 1; bus4.addr = a; bus4.i_data = 8'h00;
        bus.cs = 0; bus.rwb = 1;
        e.a = a; e.d = d; e.ib = 1'b1;
        sbq4.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cs && bus.rwb) begin
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL sb_underflow dut16 addr=%h", bus.addr);
                end else begin
                    e = sbq.pop_front();
                    n_chk++;
                    if (bus.o_data !== e.d) begin
                        n_fail++;
                        $display("FAIL rd_data addr=%h got=%h exp=%h t=%0t", e.a, bus.o_data, e.d, $time);
                    end
                    n_chk++;
                    if (irqb_master !== e.ib) begin
                        n_fail++;
                        $display("FAIL irqb_master got=%b exp=%b t=%0t", irqb_master, e.ib, $time);
                    end
                end
            end
            if (bus4.cs && bus4.rwb) begin
                if (sbq4.size() == 0) begin
                    n_chk++; n_fail++; $display("FAIL sb_underflow dut4 addr=%h", bus4.addr);
                end else begin
                    e = sbq4.pop_front();
                    n_chk += 2;
                    if (bus4.o_data !== e.d) begin
                        n_fail++;
                        $display("FAIL rd4_data addr=%h got=%h exp=%h", e.a, bus4.o_data, e.d);
                    end
                    if (irqb_master4 !== e.ib) begin
                        n_fail++;
                        $display("FAIL irqb_master4 got=%b exp=%b", irqb_master4, e.ib);
                    end
                end
            end
        end
    end

    initial begin
        bus.cs = 0; bus.rwb = 1; bus.addr = 0; bus.i_data = 0;
        bus4.cs = 0; bus4.rwb = 1; bus4.addr = 0; bus4.i_data = 0;
        idle(2);
        rd(ADDR_VECTOR, 0, 8'h80, 1'b1);
        idle(1);
        reset_n = 1'b1;
        rd(ADDR_VECTOR, 0, 8'h80, 1'b1);
        rd(4'h4, 0, 8'h00, 1'b1);
        rd(4'h8, 0, 8'h00, 1'b1);
        rd(4'hC, 0, 8'h00, 1'b1);
        wr(4'h2, 8'hFF);
        rd(4'h2, 0, 8'h00, 1'b1);

        // Edge source 0: vector at k+3, irqb low at k+4, CMD clear.
        wr(4'h4, 8'h01);
        wr(4'h8, 8'h01);
        idle(1); irqb[0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            rd(ADDR_VECTOR, 0, (j < 3) ? 8'h80 : 8'h00, (j < 4) ? 1'b1 : 1'b0);
            if (j == 0) irqb[0] = 1'b1;
        end
        wr(ADDR_CMD, 8'h00);
        rd(ADDR_VECTOR, 0, 8'h80, 1'b0);
        rd(ADDR_VECTOR, 0, 8'h80, 1'b1);

        // Level source 9: W1C has no effect, release clears.
        wr(4'h5, 8'h02); irqb[9] = 1'b0;
        idle(6);
        rd(ADDR_VECTOR, 0, 8'h09, 1'b0);
        wr(4'hD, 8'h02);
        idle(2);
        rd(4'hD, 0, 8'h02, 1'b0);
        rd(ADDR_VECTOR, 0, 8'h09, 1'b0); irqb[9] = 1'b1;
        idle(6);
        rd(ADDR_VECTOR, 0, 8'h80, 1'b1);

        // Edge sources 3 and 12: priority and CMD index / clear-all.
        wr(4'h8, 8'h09); wr(4'h9, 8'h10); wr(4'h4, 8'h09); wr(4'h5, 8'h12);
        irqb[3] = 1'b0; irqb[12] = 1'b0;
        idle(1); irqb[3] = 1'b1; irqb[12] = 1'b1;
        idle(6);
        rd(ADDR_VECTOR, 0, 8'h03, 1'b0);
        wr(ADDR_CMD, 8'h03);
        rd(ADDR_VECTOR, 0, 8'h0C, 1'b0);
        wr(ADDR_CMD, 8'h80);
        idle(1);
        rd(ADDR_VECTOR, 0, 8'h80, 1'b1);

        // Edge on 5 lands in the same cycle as its W1C: set wins.
        wr(4'h8, 8'h29);
        idle(1); irqb[5] = 1'b0;
        idle(1); irqb[5] = 1'b1;
        idle(1);
        wr(4'hC, 8'h20);
        rd(4'hC, 0, 8'h20, 1'b1);
        wr(4'hC, 8'h20);
        rd(4'hC, 0, 8'h00, 1'b1);

        // Reset while source 2 is pending and its input is held low.
        wr(4'h8, 8'h2D); irqb[2] = 1'b0;
        idle(6);
        rd(4'hC, 0, 8'h04, 1'b1);
        idle(1); reset_n = 1'b0;
        idle(2); reset_n = 1'b1;
        rd(4'hC, 0, 8'h00, 1'b1);
        rd(4'h8, 0, 8'h00, 1'b1);
        idle(6);
        wr(4'h8, 8'h04);
        idle(6);
        rd(4'hC, 0, 8'h00, 1'b1); irqb[2] = 1'b1;
        idle(6); irqb[2] = 1'b0;
        idle(6);
        rd(4'hC, 0, 8'h04, 1'b1);

        // NUM_IRQ=4 instance: bits above 3 read 0, out-of-range CMD ignored.
        wr4(4'h4, 8'hFF); wr4(4'h5, 8'hFF); wr4(4'h8, 8'hFF);
        rd4(4'h4, 8'h0F);
        rd4(4'h5, 8'h00);
        rd4(4'h8, 8'h0F);
        wr4(ADDR_CMD, 8'h07);
        rd4(4'h4, 8'h0F);
        rd4(4'h8, 8'h0F);
        rd4(4'hC, 8'h00);
        rd4(ADDR_VECTOR, 8'h80);

        // Randomised traffic against the model.
        irqb = '1;
        idle(8);
        for (int it = 0; it < 400; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                rd(4'($urandom_range(0, 15)), 1, 8'h00, 1'b0);
            end else if (op < 7) begin
                logic [3:0] a;
                logic [7:0] d;
                a = 4'($urandom_range(0, 15));
                d = 8'($urandom);
                if (a == ADDR_CMD) d = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom_range(0, 20));
                wr(a, d);
            end else begin
                int k;
                k = $urandom_range(0, N - 1);
                irqb[k] = ~irqb[k];
                idle(1);
            end
        end
        idle(2);

        n_chk++;
        if (sbq.size() != 0 || sbq4.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got=%0d/%0d exp=0/0", sbq.size(), sbq4.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
